regfile_wb: RTL and testbench

- Architectural register file for the MIPS core. It is the write-back consumer of the 3-way write-back select (PC+4 / memory / ALU).
- It accepts one write per cycle from write-back and provides two combinational read ports to decode, with write-to-read bypass.
- It holds a load scoreboard that flags registers with an outstanding load, so decode can stall on load-use hazards.
- Position: write-back stage on the write side, decode stage on the read side.

---
 rtl/regfile_wb.sv | 106 ++++++++++
 tb/tb_regfile_wb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb.sv
// Architectural register file with write-back bypass and a load scoreboard.
// One write port from write-back, two combinational read ports to decode.
module regfile_wb #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 5,
  parameter int unsigned RA_IDX = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] wb_data,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_we,
  input  logic          wb_isLd,
  input  logic          wb_isCall,
  input  logic          ld_issue,
  input  logic [AW-1:0] ld_rd,
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rt_addr,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          rs_busy,
  output logic          rt_busy,
  output logic          stall
);

  localparam int unsigned NREG = 1 << AW;

  logic [DW-1:0]   regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  logic [AW-1:0] wdst;
  logic          wr_fire;
  logic          clr_fire;
  logic          set_fire;

  // Call link overrides the destination; register 0 is never a target.
  always_comb begin
    wdst     = wb_isCall ? AW'(RA_IDX) : wb_rd;
    wr_fire  = wb_we && (wdst != '0);
    clr_fire = wr_fire && wb_isLd;
    set_fire = ld_issue && (ld_rd != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_fire) begin
      regs[wdst] <= wb_data;
    end
  end

  // Clear first so a same-register load issue keeps the bit set.
  always_comb begin
    busy_nxt = busy;
    if (clr_fire) begin
      busy_nxt[wdst] = 1'b0;
    end
    if (set_fire) begin
      busy_nxt[ld_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read port A: zero for r0, bypass a firing write, else storage.
  always_comb begin
    rs_data = regs[rs_addr];
    rs_busy = busy[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
      rs_busy = 1'b0;
    end else if (wr_fire && (rs_addr == wdst)) begin
      rs_data = wb_data;
      if (clr_fire) begin
        rs_busy = 1'b0;
      end
    end
  end

  // Read port B mirrors port A.
  always_comb begin
    rt_data = regs[rt_addr];
    rt_busy = busy[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
      rt_busy = 1'b0;
    end else if (wr_fire && (rt_addr == wdst)) begin
      rt_data = wb_data;
      if (clr_fire) begin
        rt_busy = 1'b0;
      end
    end
  end

  assign stall = rs_busy | rt_busy;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed self-checking bench for regfile_wb.
module tb_regfile_wb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] wb_rd;
  logic          wb_we;
  logic          wb_isLd;
  logic          wb_isCall;
  logic          ld_issue;
  logic [AW-1:0] ld_rd;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic          rs_busy;
  logic          rt_busy;
  logic          stall;

  int checks;
  int errors;

  regfile_wb #(.DW(DW), .AW(AW), .RA_IDX(31)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_data  (wb_data),
    .wb_rd    (wb_rd),
    .wb_we    (wb_we),
    .wb_isLd  (wb_isLd),
    .wb_isCall(wb_isCall),
    .ld_issue (ld_issue),
    .ld_rd    (ld_rd),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .rs_busy  (rs_busy),
    .rt_busy  (rt_busy),
    .stall    (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wb_data   = '0;
    wb_rd     = '0;
    wb_we     = 1'b0;
    wb_isLd   = 1'b0;
    wb_isCall = 1'b0;
    ld_issue  = 1'b0;
    ld_rd     = '0;
  endtask

  // Commit current inputs on a rising edge, then return idle at the falling edge.
  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic wr(input logic [AW-1:0] rd, input logic [DW-1:0] d, input logic is_ld);
    wb_we   = 1'b1;
    wb_rd   = rd;
    wb_data = d;
    wb_isLd = is_ld;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    idle();
    rs_addr = 5'd5;
    rt_addr = 5'd31;
    rst_n   = 1'b0;
    #12;
    check("rst_rs_data", rs_data, 32'h0);
    check("rst_rt_data", rt_data, 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_rt_data", rt_data, 32'h0);

    // Write r7, load r12, then reset mid-run discards both.
    @(negedge clk);
    wr(5'd7, 32'h0000_1234, 1'b0);
    ld_issue = 1'b1;
    ld_rd    = 5'd12;
    cycle();
    rs_addr = 5'd7;
    rt_addr = 5'd12;
    #1;
    check("r7_written", rs_data, 32'h0000_1234);
    check("r12_busy", 32'(rt_busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("r7_reset", rs_data, 32'h0);
    check("r12_busy_reset", 32'(rt_busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Bypass on r3, then storage.
    @(negedge clk);
    wr(5'd3, 32'h0000_ff00, 1'b0);
    rs_addr = 5'd3;
    rt_addr = 5'd4;
    #1;
    check("r3_bypass", rs_data, 32'h0000_ff00);
    check("r4_no_bypass", rt_data, 32'h0);
    cycle();
    #1;
    check("r3_stored", rs_data, 32'h0000_ff00);

    // Register 0 ignores writes and loads.
    wr(5'd0, 32'hdead_beef, 1'b0);
    ld_issue = 1'b1;
    ld_rd    = 5'd0;
    rs_addr  = 5'd0;
    rt_addr  = 5'd0;
    #1;
    check("r0_no_bypass", rs_data, 32'h0);
    cycle();
    #1;
    check("r0_read", rt_data, 32'h0);
    check("r0_busy", 32'(rs_busy), 32'h0);
    check("r0_stall", 32'(stall), 32'h0);

    // Call link forces destination to r31.
    wr(5'd4, 32'hff00_0000, 1'b0);
    wb_isCall = 1'b1;
    rs_addr   = 5'd31;
    rt_addr   = 5'd4;
    #1;
    check("call_bypass_r31", rs_data, 32'hff00_0000);
    check("call_r4_bypass", rt_data, 32'h0);
    cycle();
    #1;
    check("call_r31", rs_data, 32'hff00_0000);
    check("call_r4", rt_data, 32'h0);

    // Load-use on r8 and its completion.
    ld_issue = 1'b1;
    ld_rd    = 5'd8;
    rs_addr  = 5'd8;
    rt_addr  = 5'd3;
    #1;
    check("r8_busy_same_cycle", 32'(rs_busy), 32'h0);
    cycle();
    #1;
    check("r8_busy", 32'(rs_busy), 32'h1);
    check("r8_stall", 32'(stall), 32'h1);
    check("r3_not_busy", 32'(rt_busy), 32'h0);
    wr(5'd8, 32'h00ff_0000, 1'b1);
    #1;
    check("r8_clr_busy", 32'(rs_busy), 32'h0);
    check("r8_clr_stall", 32'(stall), 32'h0);
    check("r8_clr_data", rs_data, 32'h00ff_0000);
    cycle();
    #1;
    check("r8_busy_after", 32'(rs_busy), 32'h0);
    check("r8_data_after", rs_data, 32'h00ff_0000);

    // Same-register set and clear: set wins, data still written.
    wr(5'd9, 32'h0000_0099, 1'b1);
    ld_issue = 1'b1;
    ld_rd    = 5'd9;
    cycle();
    rs_addr = 5'd9;
    #1;
    check("r9_data", rs_data, 32'h0000_0099);
    check("r9_busy", 32'(rs_busy), 32'h1);

    // Different-register set and clear both apply.
    ld_issue = 1'b1;
    ld_rd    = 5'd11;
    cycle();
    rt_addr = 5'd11;
    #1;
    check("r11_busy_pre", 32'(rt_busy), 32'h1);
    wr(5'd11, 32'h0000_1111, 1'b1);
    ld_issue = 1'b1;
    ld_rd    = 5'd10;
    cycle();
    rs_addr = 5'd10;
    #1;
    check("r10_busy", 32'(rs_busy), 32'h1);
    check("r11_busy", 32'(rt_busy), 32'h0);
    check("r11_data", rt_data, 32'h0000_1111);

    // Non-load write does not clear the scoreboard.
    wr(5'd10, 32'h0000_aaaa, 1'b0);
    #1;
    check("r10_nonld_busy", 32'(rs_busy), 32'h1);
    check("r10_nonld_bypass", rs_data, 32'h0000_aaaa);
    cycle();
    #1;
    check("r10_nonld_busy_after", 32'(rs_busy), 32'h1);
    check("r10_stall", 32'(stall), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
